// File: rtl/alarm_seq_pkg.sv
// Package for the alarm sequencer: FSM state encoding, register map, CTRL/STATUS
// bit positions, time-field widths and the snooze-length helper.
//
// Optional feature macro used by importers: ALARM_SEQ_IRQ_EN (adds irq output).
package alarm_seq_pkg;

   // Encoding is visible to software through STATUS[1:0].
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StRinging = 2'd2,
      StSnooze  = 2'd3
   } alarm_state_e;

   // Register addresses
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_ALTIME = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_SNZCFG = 2'd3;

   // CTRL bit indices
   localparam int unsigned CTRL_ARM    = 0;
   localparam int unsigned CTRL_STOP   = 1;
   localparam int unsigned CTRL_SNOOZE = 2;

   // STATUS write-1-to-clear bit
   localparam int unsigned STATUS_IRQ = 3;

   // Time field widths
   localparam int unsigned HR_W       = 5;
   localparam int unsigned MIN_W      = 6;
   localparam int unsigned ALT_HR_LSB = MIN_W;
   localparam int unsigned SNZ_CNT_W  = 12;

   // Snooze reload in seconds; a programmed length of 0 minutes behaves as 1.
   // Largest value is 63 * 60 = 3780, which fits in SNZ_CNT_W bits.
   function automatic logic [SNZ_CNT_W-1:0] snooze_load(input logic [MIN_W-1:0] mins);
      logic [SNZ_CNT_W-1:0] m;
      m = (mins == '0) ? SNZ_CNT_W'(1) : SNZ_CNT_W'(mins);
      return m * SNZ_CNT_W'(60);
   endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Avalon-MM slave register bus for the alarm sequencer.
//   address    : register select (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : read data, zero-latency, driven by the slave
interface alarm_sequencer_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/alarm_beep_gen.sv
// Beep cadence generator: while enabled, a counter runs 0..BEEP_HALF-1 and the
// output toggles on every wrap. A clear restarts the cadence with the output high.
// Disabled forces the output low.
//   clk     : system clock
//   reset_n : async active-low reset
//   enable  : cadence runs (sequencer is ringing next cycle)
//   clear   : restart cadence (entry into ringing)
//   beep    : registered buzzer drive
module alarm_beep_gen #(
   parameter int unsigned BEEP_HALF = 25_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic beep
);

   localparam int unsigned CntW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(BEEP_HALF - 1);

   logic [CntW-1:0] beep_cnt_q, beep_cnt_d;
   logic            beep_q, beep_d;

   always_comb begin
      beep_cnt_d = beep_cnt_q;
      beep_d     = beep_q;
      if (!enable) begin
         beep_cnt_d = '0;
         beep_d     = 1'b0;
      end else if (clear) begin
         // First ringing cycle already drives the buzzer.
         beep_cnt_d = '0;
         beep_d     = 1'b1;
      end else if (beep_cnt_q == CntMax) begin
         beep_cnt_d = '0;
         beep_d     = ~beep_q;
      end else begin
         beep_cnt_d = beep_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beep_cnt_q <= '0;
         beep_q     <= 1'b0;
      end else begin
         beep_cnt_q <= beep_cnt_d;
         beep_q     <= beep_d;
      end
   end

   assign beep = beep_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: Avalon-MM slave that compares time of day with a programmed
// alarm time and sequences ring / snooze / stop, driving a beep cadence on alarm_out.
//   clk, reset_n        : clock, async active-low reset
//   bus (slave)         : register interface (CTRL, ALTIME, STATUS, SNZCFG)
//   sec_tick            : 1-clk pulse once per second
//   cur_hour/min/sec    : current time of day (binary)
//   alarm_out           : buzzer drive
//   irq                 : pending-interrupt output, only with ALARM_SEQ_IRQ_EN defined
module alarm_sequencer
   import alarm_seq_pkg::*;
#(
   parameter int unsigned BEEP_HALF  = 25_000_000,
   parameter int unsigned RING_MAX_S = 60,
   parameter int unsigned SNOOZE_DEF = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   alarm_sequencer_if.slave  bus,
   input  logic              sec_tick,
   input  logic [HR_W-1:0]   cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic [MIN_W-1:0]  cur_sec,
`ifdef ALARM_SEQ_IRQ_EN
   output logic              irq,
`endif
   output logic              alarm_out
);

   localparam int unsigned RingW = (RING_MAX_S > 1) ? $clog2(RING_MAX_S) : 1;
   localparam logic [RingW-1:0] RingLast = RingW'(RING_MAX_S - 1);

   alarm_state_e          state_q, state_d;
   logic                  arm_q, arm_d;
   logic [HR_W-1:0]       alt_hr_q, alt_hr_d;
   logic [MIN_W-1:0]      alt_min_q, alt_min_d;
   logic [MIN_W-1:0]      snz_cfg_q, snz_cfg_d;
   logic [RingW-1:0]      ring_cnt_q, ring_cnt_d;
   logic [SNZ_CNT_W-1:0]  snz_cnt_q, snz_cnt_d;

   logic wr_en, ctrl_wr, altime_wr, status_wr, snzcfg_wr;
   logic stop_req, snooze_req, alarm_match, ring_entry, status_irq;

   // Bus decode
   assign wr_en      = bus.chipselect & ~bus.write_n;
   assign ctrl_wr    = wr_en && (bus.address == ADDR_CTRL);
   assign altime_wr  = wr_en && (bus.address == ADDR_ALTIME);
   assign status_wr  = wr_en && (bus.address == ADDR_STATUS);
   assign snzcfg_wr  = wr_en && (bus.address == ADDR_SNZCFG);
   assign stop_req   = ctrl_wr & bus.writedata[CTRL_STOP];
   assign snooze_req = ctrl_wr & bus.writedata[CTRL_SNOOZE];

   // Only the tick that starts second 0 of the alarm minute matches, so a stop
   // inside that minute cannot re-ring.
   assign alarm_match = sec_tick && (cur_hour == alt_hr_q) && (cur_min == alt_min_q) &&
                        (cur_sec == '0);

   logic unused_wdata;
   assign unused_wdata = ^bus.writedata[31:ALT_HR_LSB+HR_W];

   // Register file next state
   always_comb begin
      arm_d     = arm_q;
      alt_hr_d  = alt_hr_q;
      alt_min_d = alt_min_q;
      snz_cfg_d = snz_cfg_q;
      if (ctrl_wr) begin
         arm_d = bus.writedata[CTRL_ARM];
      end
      if (altime_wr) begin
         alt_hr_d  = bus.writedata[ALT_HR_LSB +: HR_W];
         alt_min_d = bus.writedata[MIN_W-1:0];
      end
      if (snzcfg_wr) begin
         snz_cfg_d = bus.writedata[MIN_W-1:0];
      end
   end

   // FSM next state and second counters; ARM is the registered value, so a
   // disarm takes hold one clk after the CTRL write lands.
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      ring_entry = 1'b0;
      if (!arm_q) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StArmed;
            end
            StArmed: begin
               if (alarm_match) begin
                  state_d    = StRinging;
                  ring_cnt_d = '0;
                  ring_entry = 1'b1;
               end
            end
            StRinging: begin
               if (stop_req) begin
                  state_d = StArmed;
               end else if (snooze_req) begin
                  state_d   = StSnooze;
                  snz_cnt_d = snooze_load(snz_cfg_q);
               end else if (sec_tick) begin
                  if (ring_cnt_q == RingLast) begin
                     state_d = StArmed;
                  end else begin
                     ring_cnt_d = ring_cnt_q + 1'b1;
                  end
               end
            end
            StSnooze: begin
               if (stop_req) begin
                  state_d = StArmed;
               end else if (sec_tick) begin
                  if (snz_cnt_q == SNZ_CNT_W'(1)) begin
                     state_d    = StRinging;
                     ring_cnt_d = '0;
                     ring_entry = 1'b1;
                  end else begin
                     snz_cnt_d = snz_cnt_q - 1'b1;
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         arm_q      <= 1'b0;
         alt_hr_q   <= '0;
         alt_min_q  <= '0;
         snz_cfg_q  <= MIN_W'(SNOOZE_DEF);
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         arm_q      <= arm_d;
         alt_hr_q   <= alt_hr_d;
         alt_min_q  <= alt_min_d;
         snz_cfg_q  <= snz_cfg_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
      end
   end

   // Enable follows the next state so the buzzer is high on the first ringing
   // cycle and low on the first cycle after leaving.
   alarm_beep_gen #(
      .BEEP_HALF (BEEP_HALF)
   ) u_beep (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (state_d == StRinging),
      .clear   (ring_entry),
      .beep    (alarm_out)
   );

`ifdef ALARM_SEQ_IRQ_EN
   logic irq_pend_q, irq_pend_d;

   // Set on ring entry wins over a same-cycle software clear.
   always_comb begin
      irq_pend_d = irq_pend_q;
      if (status_wr && bus.writedata[STATUS_IRQ]) begin
         irq_pend_d = 1'b0;
      end
      if (ring_entry) begin
         irq_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_pend_q <= 1'b0;
      end else begin
         irq_pend_q <= irq_pend_d;
      end
   end

   assign irq        = irq_pend_q;
   assign status_irq = irq_pend_q;
`else
   logic unused_status_wr;
   assign unused_status_wr = status_wr;
   assign status_irq       = 1'b0;
`endif

   // Zero-latency read mux
   always_comb begin
      bus.readdata = '0;
      unique case (bus.address)
         ADDR_CTRL:   bus.readdata[CTRL_ARM] = arm_q;
         ADDR_ALTIME: bus.readdata[HR_W+MIN_W-1:0] = {alt_hr_q, alt_min_q};
         ADDR_STATUS: bus.readdata[3:0] = {status_irq, alarm_out, state_q};
         ADDR_SNZCFG: bus.readdata[MIN_W-1:0] = snz_cfg_q;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: a second-level behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alarm_sequencer;

   localparam int unsigned BH   = 4;
   localparam int unsigned RMAX = 5;
   localparam int unsigned SDEF = 1;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b1;
   logic       sec_tick = 1'b0;
   logic [4:0] cur_hour = '0;
   logic [5:0] cur_min  = '0;
   logic [5:0] cur_sec  = '0;
   logic       alarm_out;
`ifdef ALARM_SEQ_IRQ_EN
   logic       irq;
`endif

   alarm_sequencer_if bus ();

   alarm_sequencer #(
      .BEEP_HALF  (BH),
      .RING_MAX_S (RMAX),
      .SNOOZE_DEF (SDEF)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .sec_tick  (sec_tick),
      .cur_hour  (cur_hour),
      .cur_min   (cur_min),
      .cur_sec   (cur_sec),
`ifdef ALARM_SEQ_IRQ_EN
      .irq       (irq),
`endif
      .alarm_out (alarm_out)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- behavioural model ----------------
   // st: 0 idle, 1 armed, 2 ringing, 3 snooze. elapsed = seconds rung, rem = seconds
   // left in snooze, cyc = clocks since ring entry (beep is on in even half-periods).
   int         m_st = 0, m_arm = 0, m_elapsed = 0, m_rem = 0, m_cyc = 0, m_out = 0, m_irq = 0;
   int         m_cfg = SDEF;
   logic [10:0] m_alt = '0;

   always @(posedge clk or negedge reset_n) begin : model
      logic        w, stop, snz, entered;
      logic [1:0]  a;
      logic [31:0] d;
      if (!reset_n) begin
         m_st = 0; m_arm = 0; m_alt = '0; m_cfg = SDEF; m_elapsed = 0; m_rem = 0;
         m_cyc = 0; m_out = 0; m_irq = 0;
      end else begin
         w = bus.chipselect && !bus.write_n;
         a = bus.address;
         d = bus.writedata;
         stop = w && a == 2'd0 && d[1];
         snz  = w && a == 2'd0 && d[2];
         entered = 1'b0;
         if (m_arm == 0) m_st = 0;
         else begin
            case (m_st)
               0: m_st = 1;
               1: if (sec_tick && cur_hour == m_alt[10:6] && cur_min == m_alt[5:0] &&
                      cur_sec == 0) begin
                     m_st = 2; m_elapsed = 0; entered = 1'b1;
                  end
               2: if (stop) m_st = 1;
                  else if (snz) begin
                     m_st = 3; m_rem = ((m_cfg == 0) ? 1 : m_cfg) * 60;
                  end else if (sec_tick) begin
                     m_elapsed++;
                     if (m_elapsed == RMAX) m_st = 1;
                  end
               default: if (stop) m_st = 1;
                  else if (sec_tick) begin
                     m_rem--;
                     if (m_rem == 0) begin m_st = 2; m_elapsed = 0; entered = 1'b1; end
                  end
            endcase
         end
         if (m_st == 2) begin
            m_cyc = entered ? 0 : m_cyc + 1;
            m_out = ((m_cyc / BH) % 2 == 0) ? 1 : 0;
         end else m_out = 0;
         if (w && a == 2'd0) m_arm = d[0];
         if (w && a == 2'd1) m_alt = d[10:0];
         if (w && a == 2'd3) m_cfg = d[5:0];
`ifdef ALARM_SEQ_IRQ_EN
         if (w && a == 2'd2 && d[3]) m_irq = 0;
         if (entered) m_irq = 1;
`endif
      end
   end

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_arm);
         2'd1:    return 32'(m_alt);
         2'd2:    return 32'(m_st) | (32'(m_out) << 2) | (32'(m_irq) << 3);
         default: return 32'(m_cfg);
      endcase
   endfunction

   // Per-cycle compare against the model
   always @(negedge clk) begin
      logic [31:0] exp_rd;
      exp_rd = model_rd(bus.address);
      checks++;
      if (alarm_out !== m_out[0]) begin
         failures++;
         $display("FAIL model_alarm_out t=%0t got=%0b exp=%0d", $time, alarm_out, m_out);
      end
      checks++;
      if (bus.readdata !== exp_rd) begin
         failures++;
         $display("FAIL model_readdata t=%0t addr=%0d got=%0h exp=%0h", $time, bus.address,
                  bus.readdata, exp_rd);
      end
`ifdef ALARM_SEQ_IRQ_EN
      checks++;
      if (irq !== m_irq[0]) begin
         failures++;
         $display("FAIL model_irq t=%0t got=%0b exp=%0d", $time, irq, m_irq);
      end
`endif
   end

   // ---------------- stimulus helpers ----------------
   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      bus.address    = 2'd2;
      sec_tick       = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.address   = a;
      bus.writedata = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      cyc();
   endtask

   task automatic do_tick();
      sec_tick = 1'b1;
      cyc();
   endtask

   task automatic set_time(input int h, input int m, input int s);
      cur_hour = 5'(h);
      cur_min  = 6'(m);
      cur_sec  = 6'(s);
   endtask

   // Caller sits just after a clock edge with address on STATUS.
   task automatic state_is(input string name, input int exp);
      #1;
      lit(name, {30'd0, bus.readdata[1:0]}, 32'(exp));
   endtask

   int pat[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

   initial begin
      bus.address    = 2'd2;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      #1 reset_n = 1'b0;
      #12;
      lit("reset_alarm_out", 32'(alarm_out), 32'd0);
      lit("reset_status", bus.readdata, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      cyc();

      // Arm
      wr(2'd0, 32'd1);
      cyc();
      state_is("armed", 1);

      // Alarm at 07:30; the tick one second early must not ring
      wr(2'd1, 32'd478);
      bus.address = 2'd1;
      #1 lit("altime_rd", bus.readdata, 32'd478);
      bus.address = 2'd2;
      set_time(7, 29, 59);
      do_tick();
      state_is("no_early_ring", 1);
      set_time(7, 30, 0);
      do_tick();
      state_is("ring_entry", 2);
`ifdef ALARM_SEQ_IRQ_EN
      lit("irq_on_ring", 32'(irq), 32'd1);
`endif
      for (int i = 0; i < 9; i++) begin
         lit($sformatf("beep_%0d", i), 32'(alarm_out), 32'(pat[i]));
         cyc();
      end

      // Auto-stop after RMAX ticks, then no re-ring later in the minute
      set_time(7, 30, 1);
      repeat (4) do_tick();
      state_is("ring_after_4", 2);
      do_tick();
      state_is("auto_stop", 1);
      lit("auto_stop_out", 32'(alarm_out), 32'd0);
      do_tick();
      state_is("no_rering", 1);
`ifdef ALARM_SEQ_IRQ_EN
      wr(2'd2, 32'h8);
      lit("irq_clear", 32'(irq), 32'd0);
`endif

      // Snooze: 60 s with SNZCFG=1
      set_time(7, 30, 0);
      do_tick();
      state_is("ring2", 2);
      wr(2'd0, 32'h5);
      state_is("snooze", 3);
      lit("snooze_out", 32'(alarm_out), 32'd0);
`ifdef ALARM_SEQ_IRQ_EN
      wr(2'd2, 32'h8);
      lit("irq_clear_snz", 32'(irq), 32'd0);
`endif
      set_time(7, 31, 0);
      repeat (59) do_tick();
      state_is("snooze_59", 3);
      do_tick();
      state_is("snooze_rering", 2);
`ifdef ALARM_SEQ_IRQ_EN
      lit("irq_rering", 32'(irq), 32'd1);
`endif

      // STOP has priority over SNOOZE; pulses read back as 0
      wr(2'd0, 32'h7);
      state_is("stop_priority", 1);
      bus.address = 2'd0;
      #1 lit("ctrl_rd", bus.readdata, 32'd1);
      bus.address = 2'd2;

      // STOP/SNOOZE while armed are ignored
      wr(2'd0, 32'h7);
      cyc();
      state_is("armed_ignore", 1);

      // Disarm while ringing
      set_time(7, 30, 0);
      do_tick();
      state_is("ring3", 2);
      wr(2'd0, 32'h0);
      cyc();
      state_is("disarm", 0);
      lit("disarm_out", 32'(alarm_out), 32'd0);

      // SNZCFG=0 behaves as one minute
      wr(2'd0, 32'd1);
      cyc();
      wr(2'd3, 32'd0);
      set_time(7, 30, 0);
      do_tick();
      wr(2'd0, 32'h5);
      state_is("cfg0_snooze", 3);
      repeat (59) do_tick();
      state_is("cfg0_59", 3);
      do_tick();
      state_is("cfg0_rering", 2);
      lit("cfg0_out", 32'(alarm_out), 32'd1);

      // Asynchronous reset mid-ring
      #2 reset_n = 1'b0;
      #1;
      lit("async_rst_out", 32'(alarm_out), 32'd0);
      lit("async_rst_status", bus.readdata, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      cyc();
      state_is("post_rst_idle", 0);
      bus.address = 2'd3;
      #1 lit("post_rst_snzcfg", bus.readdata, 32'(SDEF));
      bus.address = 2'd1;
      #1 lit("post_rst_altime", bus.readdata, 32'd0);
      bus.address = 2'd2;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
